// File: rtl/sbox_pkg.sv
// Shared definitions for the S-box generator / assembler pair.
`timescale 1ns/1ps
package sbox_pkg;

    localparam int SBOX_WIDTH = 8;
    localparam int SBOX_DEPTH = 2 ** SBOX_WIDTH;

    // Assembler build phases, also exported on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } sbox_state_e;

endpackage

// File: rtl/sbox_table_ram.sv
// DEPTH x WIDTH table: one synchronous write port, one registered read port.
// A read of the address being written returns the old content.
`timescale 1ns/1ps
module sbox_table_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Storage array: written on we, never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sbox_assembler.sv
// Builds a bijective S-box and its inverse from a byte stream, rejecting
// duplicates and sweeping in the unused values if duplicates stall the build.
`timescale 1ns/1ps
module sbox_assembler
    import sbox_pkg::*;
#(
    parameter int WIDTH        = SBOX_WIDTH,
    parameter int REJECT_LIMIT = 1024,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_byte,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH:0]       fill_count,
    output logic [CNT_WIDTH-1:0] dup_count,
    input  logic [WIDTH-1:0]     fwd_addr,
    output logic [WIDTH-1:0]     fwd_data,
    input  logic [WIDTH-1:0]     inv_addr,
    output logic [WIDTH-1:0]     inv_data,
    output logic [1:0]           dbg_state
);

    // Stream handshake: in_byte is taken on every clock where in_valid=1;
    // there is no ready, so bytes arriving outside FILL are simply dropped.

    localparam int DEPTH = 2 ** WIDTH;
    localparam int REJ_W = $clog2(REJECT_LIMIT + 1);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] FILL  = ST_FILL;
    localparam logic [1:0] SWEEP = ST_SWEEP;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]       state;
    logic [DEPTH-1:0] used;
    logic [REJ_W-1:0] rej_cnt;
    logic [WIDTH-1:0] sweep_ptr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic             last_write;
    logic             rej_hit;

    assign busy       = (state == FILL) || (state == SWEEP);
    assign done       = (state == DONE);
    assign dbg_state  = state;
    assign last_write = (fill_count == (WIDTH+1)'(DEPTH - 1));
    assign rej_hit    = (rej_cnt == REJ_W'(REJECT_LIMIT - 1));

    // Select the value to append this cycle; start suppresses any write.
    always_comb begin
        wr_en  = 1'b0;
        wr_val = '0;
        case (state)
            FILL: begin
                if (in_valid && !used[in_byte]) begin
                    wr_en  = 1'b1;
                    wr_val = in_byte;
                end
            end
            SWEEP: begin
                if (!used[sweep_ptr]) begin
                    wr_en  = 1'b1;
                    wr_val = sweep_ptr;
                end
            end
            default: ;
        endcase
        if (start) begin
            wr_en = 1'b0;
        end
    end

    // Build control: state, used bitmap, fill/duplicate counters, sweep pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            used       <= '0;
            fill_count <= '0;
            dup_count  <= '0;
            rej_cnt    <= '0;
            sweep_ptr  <= '0;
        end else if (start) begin
            state      <= FILL;
            used       <= '0;
            fill_count <= '0;
            dup_count  <= '0;
            rej_cnt    <= '0;
            sweep_ptr  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (wr_en) begin
                        used[wr_val] <= 1'b1;
                        fill_count   <= fill_count + 1'b1;
                        rej_cnt      <= '0;
                        if (last_write) state <= DONE;
                    end else if (in_valid) begin
                        if (dup_count != '1) dup_count <= dup_count + 1'b1;
                        rej_cnt <= rej_cnt + 1'b1;
                        if (rej_hit) state <= SWEEP;
                    end
                end
                SWEEP: begin
                    sweep_ptr <= sweep_ptr + 1'b1;
                    if (wr_en) begin
                        used[wr_val] <= 1'b1;
                        fill_count   <= fill_count + 1'b1;
                        if (last_write) state <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Forward table: position -> value.
    sbox_table_ram #(.ADDR_WIDTH(WIDTH), .DATA_WIDTH(WIDTH)) u_fwd_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_en),
        .waddr   (fill_count[WIDTH-1:0]),
        .wdata   (wr_val),
        .raddr   (fwd_addr),
        .rdata   (fwd_data)
    );

    // Inverse table: value -> position.
    sbox_table_ram #(.ADDR_WIDTH(WIDTH), .DATA_WIDTH(WIDTH)) u_inv_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_en),
        .waddr   (wr_val),
        .wdata   (fill_count[WIDTH-1:0]),
        .raddr   (inv_addr),
        .rdata   (inv_data)
    );

endmodule

// File: tb/tb_sbox_assembler.sv
// Self-checking bench for sbox_assembler against a list-based table model.
`timescale 1ns/1ps
module tb_sbox_assembler;
    import sbox_pkg::*;

    localparam int D   = 256;
    localparam int LIM = 4;

    // Clock / reset block
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = '0;
    logic [7:0]  fwd_addr = '0;
    logic [7:0]  inv_addr = '0;
    logic        busy, done;
    logic [8:0]  fill_count;
    logic [15:0] dup_count;
    logic [7:0]  fwd_data, inv_data;
    logic [1:0]  dbg_state;

    sbox_assembler #(.WIDTH(8), .REJECT_LIMIT(LIM), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .busy       (busy),
        .done       (done),
        .fill_count (fill_count),
        .dup_count  (dup_count),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
        .inv_addr   (inv_addr),
        .inv_data   (inv_data),
        .dbg_state  (dbg_state)
    );

    // Scoreboard bookkeeping
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the table is the ordered list of accepted values.
    // phase 0 = not building, 1 = building, 2 = complete.
    int m_phase;
    int m_fill, m_dup, m_run;
    bit m_swept;
    bit m_used[D];
    int m_fwd[D];
    int m_inv[D];
    bit saw_sweep;

    function automatic void model_clear(input int phase);
        m_phase = phase; m_fill = 0; m_dup = 0; m_run = 0; m_swept = 0;
        foreach (m_used[i]) m_used[i] = 0;
    endfunction

    function automatic void model_append(input int v);
        m_fwd[m_fill] = v;
        m_inv[v] = m_fill;
        m_used[v] = 1;
        m_fill++;
    endfunction

    function automatic void model_byte(input int b);
        if (m_phase != 1) return;
        if (m_used[b]) begin
            if (m_dup < 65535) m_dup++;
            m_run++;
            if (m_run == LIM) begin
                m_swept = 1;
                for (int v = 0; v < D; v++) if (!m_used[v]) model_append(v);
            end
        end else begin
            model_append(b);
            m_run = 0;
        end
        if (m_fill == D) m_phase = 2;
    endfunction

    always @(negedge clk) if (dbg_state == ST_SWEEP) saw_sweep = 1'b1;

    // Driver tasks
    task automatic send(input logic v, input logic [7:0] b);
        @(negedge clk);
        in_valid = v;
        in_byte  = b;
        if (v) model_byte(int'(b));
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        model_clear(1);
        saw_sweep = 1'b0;
    endtask

    task automatic lookup(input logic [7:0] a, output logic [7:0] fd, output logic [7:0] id);
        @(negedge clk);
        fwd_addr = a; inv_addr = a;
        @(posedge clk);
        #1;
        fd = fwd_data; id = inv_data;
    endtask

    // Wait for completion when the model says the build finished, bounded.
    task automatic settle(input string tag);
        int cyc;
        cyc = 0;
        if (m_phase == 2) begin
            while (!done && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 400) check_val({tag, "_timeout"}, 32'(cyc), 32'd0);
        end else begin
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] fd, id;
        settle(tag);
        check_val({tag, "_busy"}, 32'(busy), 32'(m_phase == 1));
        check_val({tag, "_done"}, 32'(done), 32'(m_phase == 2));
        check_val({tag, "_fill"}, 32'(fill_count), 32'(m_fill));
        check_val({tag, "_dup"}, 32'(dup_count), 32'(m_dup));
        check_val({tag, "_sweep"}, 32'(saw_sweep), 32'(m_swept));
        for (int i = 0; i < D; i++) begin
            lookup(8'(i), fd, id);
            if (i < m_fill) begin
                exp_q.push_back(32'(m_fwd[i]));
                check_val({tag, "_fwd"}, 32'(fd), exp_q.pop_front());
            end
            if (m_used[i]) begin
                exp_q.push_back(32'(m_inv[i]));
                check_val({tag, "_inv"}, 32'(id), exp_q.pop_front());
            end
        end
    endtask

    initial begin
        logic [7:0] fd, id;
        int len, lo, hi;
        model_clear(0);
        saw_sweep = 1'b0;

        // Reset values
        #23;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_fill", 32'(fill_count), 0);
        check_val("rst_dup", 32'(dup_count), 0);
        check_val("rst_fwd_data", 32'(fwd_data), 0);
        check_val("rst_inv_data", 32'(inv_data), 0);
        @(negedge clk);
        reset_n = 1'b1;
        // IDLE ignores input
        for (int i = 0; i < 4; i++) send(1'b1, 8'(i));
        idle_in();
        check_val("idle_fill", 32'(fill_count), 0);
        check_val("idle_busy", 32'(busy), 0);

        // Ascending stream, with done timing at the last byte
        pulse_start();
        check_val("start_busy", 32'(busy), 1);
        for (int i = 0; i < 255; i++) send(1'b1, 8'(i));
        @(negedge clk);
        in_valid = 1'b1; in_byte = 8'd255; model_byte(255);
        check_val("asc_done_before", 32'(done), 0);
        @(posedge clk);
        #1;
        check_val("asc_done_after", 32'(done), 1);
        idle_in();
        check_all("asc");

        // Descending stream
        pulse_start();
        for (int i = 255; i >= 0; i--) send(1'b1, 8'(i));
        idle_in();
        check_all("desc");
        lookup(8'd0, fd, id);   check_val("desc_fwd0", 32'(fd), 255); check_val("desc_inv0", 32'(id), 255);
        lookup(8'd255, fd, id); check_val("desc_fwd255", 32'(fd), 0); check_val("desc_inv255", 32'(id), 0);

        // Duplicate rejection
        pulse_start();
        send(1'b1, 8'd5); send(1'b1, 8'd5); send(1'b1, 8'd7);
        idle_in();
        check_all("dup");
        check_val("dup_fill_k", 32'(fill_count), 2);
        check_val("dup_cnt_k", 32'(dup_count), 1);
        lookup(8'd0, fd, id); check_val("dup_fwd0", 32'(fd), 5);
        lookup(8'd1, fd, id); check_val("dup_fwd1", 32'(fd), 7);
        lookup(8'd7, fd, id); check_val("dup_inv7", 32'(id), 1);

        // Sweep after LIM consecutive duplicates
        pulse_start();
        send(1'b1, 8'd10); send(1'b1, 8'd20);
        for (int i = 0; i < 4; i++) send(1'b1, 8'd10);
        idle_in();
        check_all("sweep");
        lookup(8'd2, fd, id);   check_val("sw_fwd2", 32'(fd), 0);
        lookup(8'd11, fd, id);  check_val("sw_fwd11", 32'(fd), 9);
        lookup(8'd12, fd, id);  check_val("sw_fwd12", 32'(fd), 11);
        lookup(8'd20, fd, id);  check_val("sw_fwd20", 32'(fd), 19); check_val("sw_inv20", 32'(id), 1);
        lookup(8'd21, fd, id);  check_val("sw_fwd21", 32'(fd), 21);
        lookup(8'd255, fd, id); check_val("sw_fwd255", 32'(fd), 255);

        // start wins over a same-cycle byte
        pulse_start();
        for (int i = 0; i < 100; i++) send(1'b1, 8'((i * 7 + 11) % 256));
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; in_byte = 8'd3;
        model_clear(1);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        check_val("restart_fill", 32'(fill_count), 0);
        check_val("restart_dup", 32'(dup_count), 0);
        send(1'b1, 8'd3);
        idle_in();
        check_all("restart");
        lookup(8'd0, fd, id); check_val("restart_fwd0", 32'(fd), 3);

        // Asynchronous reset mid-build
        pulse_start();
        for (int i = 0; i < 50; i++) send(1'b1, 8'(i));
        idle_in();
        check_val("pre_rst_fill", 32'(fill_count), 50);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 0);
        check_val("arst_done", 32'(done), 0);
        check_val("arst_fill", 32'(fill_count), 0);
        check_val("arst_fwd_data", 32'(fwd_data), 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear(0);
        for (int i = 0; i < 5; i++) send(1'b1, 8'(100 + i));
        idle_in();
        check_val("post_rst_fill", 32'(fill_count), 0);
        check_val("post_rst_busy", 32'(busy), 0);
        check_val("post_rst_done", 32'(done), 0);

        // Randomized streams: full range, narrow range, short partial
        for (int it = 0; it < 6; it++) begin
            pulse_start();
            case (it % 3)
                0:       begin len = 700; lo = 0; hi = 255; end
                1:       begin len = 200; lo = 0; hi = $urandom_range(8, 40); end
                default: begin len = 150; lo = 0; hi = 255; end
            endcase
            for (int i = 0; i < len; i++)
                send(1'($urandom_range(0, 9) < 8), 8'($urandom_range(lo, hi)));
            idle_in();
            check_all($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
